vga_scanout: RTL
================

# vga_scanout

Pixel-clock scan-out engine for the 160x120, 4-bit-per-pixel framebuffer. It generates 640x480@60 Hz VGA timing and drives the framebuffer read coordinates, scaling each framebuffer pixel to a 4x4 screen cell. It samples the 4-bit colour index returned by the framebuffer, maps it through a palette to 12-bit RGB, and drives the board's VGA pins with sync aligned to colour.

## Interface
Parameters:
- none; all timing constants come from `vga_pkg`.

Ports:
- `i_clk` — in, 1 — pixel clock, 25.175 MHz nominal; same net as the framebuffer's `i_vga_clk`.
- `i_rst_n` — in, 1 — reset, asynchronous and active-low.
- `i_value` — in, 4 — colour index returned by the framebuffer.
- `o_pxlX` — out, 8 — framebuffer X read coordinate.
- `o_pxlY` — out, 8 — framebuffer Y read coordinate.
- `o_hsync` — out, 1 — horizontal sync, active-low.
- `o_vsync` — out, 1 — vertical sync, active-low.
- `o_red` — out, 4 — red channel.
- `o_green` — out, 4 — green channel.
- `o_blue` — out, 4 — blue channel.
- `o_frameStart` — out, 1 — one-cycle pulse at hcnt=0, vcnt=0.
- `o_vblank` — out, 1 — high while vcnt ≥ 480 (undelayed).
- `i_palWe` — in, 1 — palette write strobe. Present only with `VGA_PALETTE_EN`.
- `i_palIdx` — in, 4 — palette entry to write. Present only with `VGA_PALETTE_EN`.
- `i_palData` — in, 12 — palette entry value, {R[11:8], G[7:4], B[3:0]}. Present only with `VGA_PALETTE_EN`.

## Operation
Counters:
- `hcnt` is 10 bits, counts 0..799, then wraps to 0.
- `vcnt` is 10 bits, increments when hcnt wraps, counts 0..524, then wraps to 0.

Horizontal timing (hcnt):
- active 0–639
- front porch 640–655
- sync 656–751
- back porch 752–799

Vertical timing (vcnt):
- active 0–479
- front porch 480–489
- sync 490–491
- back porch 492–524

Read coordinates:
- `o_pxlX` = hcnt[9:2] when hcnt < 640, else 8'd255.
- `o_pxlY` = vcnt[9:2] when vcnt < 480, else 8'd255.
- Both are combinational from the counter registers.
- 255 is out of range for the framebuffer, so it returns index 0 during blanking.

Colour sample register:
- Loads `i_value` only on cycles where hcnt[1:0] = 2'b11, the last cycle of each 4-clock cell.
- By then the coordinate has been stable for 3 clocks, which hides the framebuffer's 1-clock read latency and its pixel-select skew at word boundaries.
- Holds its value for 4 clocks.

Palette stage:
- Registered lookup of the sample register into 12-bit RGB.
- Output RGB is forced to 0 when the delayed blank flag is set.

Sync and blank alignment:
- Raw hsync, vsync and blank are computed from the counters.
- Each is delayed 5 clocks through a shift register so it stays aligned with RGB.

Boundary conditions:
- When vcnt wraps together with hcnt, both counters clear on the same edge.
- The last cell of a line (hcnt 636–639) is sampled at hcnt=639.
- That cell's RGB is therefore displayed on hcnt 641–644, under the delayed active window.

## Timing
- Reset values (asynchronous):
  - hcnt = 0, vcnt = 0
  - sample register = 0, RGB = 0
  - sync delay line = 1 (inactive); blank delay line = 1
  - `o_hsync` = 1, `o_vsync` = 1
  - `o_red`, `o_green`, `o_blue` = 0
  - `o_frameStart` = 0
- Reset release: the first counted cycle is hcnt=0, vcnt=0.
- `o_frameStart` pulses on that first counted cycle.
- Pipeline latency: a cell whose first clock is hcnt=4c first appears on the RGB outputs at hcnt=4c+5 and is held for 4 clocks.
- All of `o_hsync`, `o_vsync` and blanking have the same 5-clock delay as RGB.
- Reset asserted mid-frame: every output returns to its reset value immediately.
- After reset deasserts, scan restarts at the top-left pixel; no partial line is emitted.

## Configuration
`VGA_PALETTE_EN` defined:
- 16 x 12-bit palette register file, reset to grayscale: entry n = {n, n, n}.
- Write port: when `i_palWe` is high, entry `i_palIdx` takes `i_palData` at the clock edge.
- Writes are accepted at any time, including during active video.
- A lookup of the same index in the same cycle as its write returns the old value.
- The new value is visible from the next lookup.

`VGA_PALETTE_EN` undefined:
- The palette ports are absent.
- Mapping is a fixed grayscale: R = G = B = index.

## Structure
- `vga_pkg` holds:
  - horizontal/vertical active, front-porch, sync and back-porch constants, plus the two totals
  - `SCAN_LATENCY` = 5
  - `rgb12_t` packed struct {r, g, b}
- Sub-module `vga_palette` contains the lookup register, the optional register file and the grayscale fallback.
- Counters, coordinate generation and delay lines stay in `vga_scanout`.

## Test plan
1. **Reset release:** assert `i_rst_n`=0 for 3 clocks, then release → during reset `o_hsync`=`o_vsync`=1 and RGB=0; `o_frameStart` pulses on the first cycle after release.
2. **Line timing:** run one full line → `o_hsync` is low for exactly 96 clocks, starting 661 clocks after the line's hcnt=0 (656+5); line period is 800 clocks. Frame: `o_vsync` is low for 2 lines; frame period is 420000 clocks.
3. **Coordinate mapping:** a framebuffer model returns index = X[3:0] → `o_pxlX` = 0,0,0,0,1,… in active area and 255 in blanking; RGB shows grayscale 0,1,2,… with each level held 4 clocks, starting 5 clocks after hcnt=0.
4. **Sample skew immunity:** the model glitches `i_value` to 4'hF on the first clock of every cell → output never shows 4'hF.
5. **Palette write (`VGA_PALETTE_EN`):** write index 3 = 12'hF00 mid-line while displaying index 3 → pixels sampled after the write show R=F, G=0, B=0; earlier pixels keep 3,3,3.
6. **Mid-frame reset:** assert reset at vcnt=200, hcnt=300 → outputs go to reset values immediately; after release, scan restarts at vcnt=0, hcnt=0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 VGA timing constants and shared types for the scan-out engine.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCAN_LATENCY = 5;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;
endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read, VGA pin and status signals of vga_scanout.
// VGA_PALETTE_EN adds the palette write port.
interface vga_scanout_if;
    import vga_pkg::*;
    logic [3:0] value;
    logic [7:0] pxl_x;
    logic [7:0] pxl_y;
    logic hsync;
    logic vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic frame_start;
    logic vblank;
`ifdef VGA_PALETTE_EN
    logic pal_we;
    logic [3:0] pal_idx;
    logic [11:0] pal_data;
    modport master (input value, pal_we, pal_idx, pal_data,
                    output pxl_x, pxl_y, hsync, vsync, red, green, blue, frame_start, vblank);
    modport slave (output value, pal_we, pal_idx, pal_data,
                   input pxl_x, pxl_y, hsync, vsync, red, green, blue, frame_start, vblank);
`else
    modport master (input value,
                    output pxl_x, pxl_y, hsync, vsync, red, green, blue, frame_start, vblank);
    modport slave (output value,
                   input pxl_x, pxl_y, hsync, vsync, red, green, blue, frame_start, vblank);
`endif
endinterface

// File: rtl/vga_palette.sv
// vga_palette: registered colour-index to 12-bit RGB lookup.
// VGA_PALETTE_EN: writable 16-entry palette (reset to grayscale); otherwise fixed grayscale.
module vga_palette
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  idx,
`ifdef VGA_PALETTE_EN
    input  logic        we,
    input  logic [3:0]  wr_idx,
    input  logic [11:0] wr_data,
`endif
    output rgb12_t      rgb
);
`ifdef VGA_PALETTE_EN
    rgb12_t pal [16];
    // Lookup reads the pre-write entry, so a same-cycle write shows up on the next lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < 16; n++) pal[n] <= rgb12_t'({3{4'(n)}});
            rgb <= '0;
        end else begin
            if (we) pal[wr_idx] <= rgb12_t'(wr_data);
            rgb <= pal[idx];
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rgb <= '0;
        else rgb <= rgb12_t'({idx, idx, idx});
    end
`endif
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA scan-out of a 160x120x4 framebuffer in 4x4 screen cells.
// VGA_PALETTE_EN: use the writable palette instead of fixed grayscale.
module vga_scanout
    import vga_pkg::*;
(
    input logic           i_clk,
    input logic           i_rst_n,
    vga_scanout_if.master bus
);
    logic [9:0] hcnt, vcnt;
    logic [3:0] sample;
    logic [SCAN_LATENCY-1:0] hs_d, vs_d, blank_d;
    logic h_act, v_act, h_end, v_end, hs_raw, vs_raw;
    rgb12_t rgb;
    always_comb begin
        h_act = hcnt < 10'(H_ACTIVE);
        v_act = vcnt < 10'(V_ACTIVE);
        h_end = hcnt == 10'(H_TOTAL - 1);
        v_end = vcnt == 10'(V_TOTAL - 1);
        hs_raw = !(hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC));
        vs_raw = !(vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    end
    assign bus.pxl_x = h_act ? hcnt[9:2] : 8'd255;
    assign bus.pxl_y = v_act ? vcnt[9:2] : 8'd255;
    assign bus.vblank = !v_act;
    assign bus.frame_start = i_rst_n && hcnt == '0 && vcnt == '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_end ? '0 : hcnt + 10'd1;
            if (h_end) vcnt <= v_end ? '0 : vcnt + 10'd1;
        end
    end
    // Sample on the last clock of each cell, after the read coordinate has settled for 3 clocks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sample <= '0;
        else if (hcnt[1:0] == 2'b11) sample <= bus.value;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_d <= '1;
            vs_d <= '1;
            blank_d <= '1;
        end else begin
            hs_d <= {hs_d[SCAN_LATENCY-2:0], hs_raw};
            vs_d <= {vs_d[SCAN_LATENCY-2:0], vs_raw};
            blank_d <= {blank_d[SCAN_LATENCY-2:0], !(h_act && v_act)};
        end
    end
    vga_palette u_pal (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .idx     (sample),
`ifdef VGA_PALETTE_EN
        .we      (bus.pal_we),
        .wr_idx  (bus.pal_idx),
        .wr_data (bus.pal_data),
`endif
        .rgb     (rgb)
    );
    assign bus.hsync = hs_d[SCAN_LATENCY-1];
    assign bus.vsync = vs_d[SCAN_LATENCY-1];
    assign bus.red = blank_d[SCAN_LATENCY-1] ? 4'd0 : rgb.r;
    assign bus.green = blank_d[SCAN_LATENCY-1] ? 4'd0 : rgb.g;
    assign bus.blue = blank_d[SCAN_LATENCY-1] ? 4'd0 : rgb.b;
endmodule
